// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master for an 8-channel 12-bit serial ADC.
// Each frame sends the next channel address and reads back the result of
// the previous frame's conversion. The block therefore remembers which
// channel the in-flight data belongs to.
module adc_spi_reader #(
    parameter int CLK_DIV    = 4,   // sclk half-period in clk cycles, >= 2
    parameter int FRAME_BITS = 16,  // sclk cycles per frame
    parameter int DATA_BITS  = 12   // result width, low bits of the frame
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [2:0]           channel_addr,
    output logic                 busy,
    output logic                 sample_valid,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [2:0]           sample_channel,
    output logic                 spi_cs_n,
    output logic                 spi_sclk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] tx_load;
    // Only the low DATA_BITS of the frame matter; leading zeros shift out.
    logic [DATA_BITS-1:0]  rx;
    logic [2:0]            cur_addr;
    logic [2:0]            prev_addr;
    logic                  primed;
    logic                  div_last;
    logic                  bit_last;

    // Outgoing control word: two don't-care zeros, address, then zeros.
    always_comb begin
        tx_load  = {2'b00, channel_addr, {(FRAME_BITS-5){1'b0}}};
        div_last = (div_cnt == CW'(CLK_DIV - 1));
        bit_last = (bit_cnt == BW'(FRAME_BITS - 1));
    end

    // Frame sequencer: SETUP (cs low, sclk high), 16 low-then-high sclk
    // periods, HOLD, then a mandatory IDLE cycle with cs high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            tx             <= '0;
            rx             <= '0;
            cur_addr       <= '0;
            prev_addr      <= '0;
            primed         <= 1'b0;
            busy           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
            sample_channel <= '0;
            spi_cs_n       <= 1'b1;
            spi_sclk       <= 1'b1;
            spi_mosi       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b1;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    if (start) begin
                        cur_addr <= channel_addr;
                        tx       <= tx_load;
                        spi_mosi <= tx_load[FRAME_BITS-1];
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        // First falling edge re-drives bit 0 unchanged.
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= tx[FRAME_BITS-1];
                        tx       <= tx << 1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            // Rising edge: ADC data has been stable for a
                            // half period, so miso is sampled directly.
                            spi_sclk <= 1'b1;
                            rx       <= {rx[DATA_BITS-2:0], spi_miso};
                        end else if (bit_last) begin
                            // High half of the last period done.
                            state <= HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            spi_sclk <= 1'b0;
                            spi_mosi <= tx[FRAME_BITS-1];
                            tx       <= tx << 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt   <= '0;
                        spi_cs_n  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        // Data just read belongs to the previous frame's
                        // address; the first frame after reset has none.
                        if (primed) begin
                            sample_valid   <= 1'b1;
                            sample_data    <= rx;
                            sample_channel <= prev_addr;
                        end
                        primed    <= 1'b1;
                        prev_addr <= cur_addr;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
